// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

  // Rsvd behaves like None: only the two defined codes enable a parity bit.
  function automatic logic parity_active(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on rdata
// whenever the FIFO is non-empty.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(Depth));
  assign empty   = (count_reg == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: FIFO plus baud-tick-driven serialiser.
// Define UART_TX_PARITY_EN to compile in the parity bit; otherwise parity_mode_i is ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned StopBits  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          baud_clk_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          valid_i,
  input  logic [DataWidth-1:0]          data_i,
  output logic                          ready_o,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FifoDepth):0]    fifo_count_o
);

  localparam int unsigned CW = $clog2(DataWidth);

  if (DataWidth < DATA_WIDTH_MIN || DataWidth > DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_frame: DataWidth out of range");
  end
  if (StopBits < STOP_BITS_MIN || StopBits > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_tx_frame: StopBits out of range");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FifoDepth must be a power of two >= 2");
  end

  uart_tx_state_e       state_reg, state_next;
  logic [DataWidth-1:0] shift_reg, shift_next;
  logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 txd_reg, txd_next;
  logic                 start_frame;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DataWidth-1:0] fifo_rdata;

`ifdef UART_TX_PARITY_EN
  logic par_en_reg, par_en_next;
  logic par_bit_reg, par_bit_next;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode_i;
`endif

  uart_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (valid_i),
    .pop   (fifo_pop),
    .wdata (data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  assign ready_o = !fifo_full;
  assign txd_o   = txd_reg;
  assign busy_o  = (state_reg != ST_IDLE) || (fifo_count_o != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      txd_reg      <= txd_next;
`ifdef UART_TX_PARITY_EN
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    txd_next      = txd_reg;
    start_frame   = 1'b0;
    fifo_pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
`endif
    if (baud_clk_i) begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) start_frame = 1'b1;
        end
        ST_START: begin
          txd_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
          state_next = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_reg == CW'(DataWidth - 1)) begin
            state_next = ST_STOP;
            txd_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_reg) begin
              state_next = ST_PARITY;
              txd_next   = par_bit_reg;
            end
`endif
          end else begin
            txd_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          txd_next   = 1'b1;
          state_next = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_cnt_reg == 1'(StopBits - 1)) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_next  = ST_IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          txd_next   = 1'b1;
        end
      endcase
    end

    // Shared by Idle and Stop so back-to-back frames start with no idle gap.
    if (start_frame) begin
      fifo_pop      = 1'b1;
      shift_next    = fifo_rdata;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
      txd_next      = 1'b0;
      state_next    = ST_START;
`ifdef UART_TX_PARITY_EN
      par_en_next   = parity_active(parity_mode_i);
      par_bit_next  = (^fifo_rdata) ^ (parity_mode_i == PAR_ODD);
`endif
    end
  end

endmodule
